byte_to_word_packer: RTL and testbench
======================================

BYTE_TO_WORD_PACKER -- requirements
Module: byte_to_word_packer

Interface
REQ-001 SHALL have parameter MD_BYTES, default 8, range 1..8: number of leading packet bytes captured as metadata.
REQ-002 SHALL have parameter MAX_PKT_BYTES, default 2048, range 16..4095: maximum payload bytes before truncation.
REQ-003 SHALL have port i_clk  input  1  the single clock; every register samples on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port iv_data  input  9  [8] is the packet marker (first and last byte of a packet), [7:0] is the byte.
REQ-006 SHALL have port i_data_wr  input  1  byte valid; no backpressure exists.
REQ-007 SHALL have port ov_data  output  134  word: [133:132] is the flag (01 head, 11 body, 10 tail), [131:128] is the invalid-byte count, [127:0] is the data, first byte in [127:120].
REQ-008 SHALL have port o_data_wr  output  1  one-cycle strobe marking ov_data valid.
REQ-009 SHALL have port ov_metadata  output  64  metadata bytes, right-aligned, first byte most significant, unused upper bytes zero.
REQ-010 SHALL have port o_metadata_wr  output  1  strobe coincident with the tail word.
REQ-011 SHALL have port ov_pkt_len  output  12  payload byte count, valid while o_metadata_wr is high.
REQ-012 SHALL have port o_pkt_err  output  1  high with the tail word of a truncated packet.
REQ-013 SHALL have ports ov_short_cnt and ov_long_cnt  output  16 each  saturating error counters.

Function
REQ-014 SHALL implement the states IDLE_S, MD_S, DATA_S and DROP_S.
REQ-015 SHALL freeze all state and counters on any cycle where i_data_wr=0, in every state; gaps are allowed anywhere in a packet.
REQ-016 IDLE_S: a write with marker=1 SHALL capture the byte as metadata byte 0, then enter MD_S, or DATA_S if MD_BYTES=1; a write with marker=0 SHALL be ignored.
REQ-017 MD_S: each write SHALL shift into metadata; after MD_BYTES bytes in total, enter DATA_S with the word byte index at 0 and the length at 0.
REQ-018 MD_S: a marker=1 byte SHALL be treated as a short packet: no output, ov_short_cnt incremented (saturating at 0xFFFF), return to IDLE_S.
REQ-019 DATA_S: each write SHALL place the byte at lane index i, in bits [127-8i:120-8i], and increment i and the length.
REQ-020 When i wraps from 15 to 0 without a marker, the block SHALL emit a full word: flag 01 if it is the first word of the packet, else 11; invalid count 0.
REQ-021 A marker=1 byte in DATA_S SHALL emit a tail word: flag 10, invalid count = 15-i, lanes after i zeroed, o_metadata_wr=1, ov_pkt_len = length including this byte; return to IDLE_S.
REQ-022 A single-word packet SHALL carry flag 10; no head word is emitted.
REQ-023 A payload byte that would make the length exceed MAX_PKT_BYTES, with no marker, SHALL close the packet: emit the pending lanes as a tail with o_pkt_err=1, o_metadata_wr=1, ov_pkt_len=MAX_PKT_BYTES; increment ov_long_cnt; enter DROP_S and discard that byte.
REQ-024 If the truncation point falls on a full word (i=0), the tail SHALL be the last full word with invalid count 0, not an empty word.
REQ-025 DROP_S: bytes SHALL be discarded until a marker=1 write, then return to IDLE_S.
REQ-026 Latency: the output word, with its strobes, SHALL be registered on the clock after the byte that completes it.
REQ-027 o_data_wr, o_metadata_wr and o_pkt_err SHALL be single-cycle pulses; ov_data, ov_metadata and ov_pkt_len SHALL hold between pulses.
REQ-028 Length and lane counters SHALL be unsigned with no wrap: the length is bounded by REQ-023 and the lane index is 4 bits, wrapping mod 16.

Reset
REQ-029 On i_rst_n=0, at any time including mid-packet, all outputs, counters and the error counters SHALL go to 0 and the state to IDLE_S.
REQ-030 After reset release, bytes of a partially received packet SHALL be ignored until the next marker=1 byte, which is taken as a packet start.

Structure
REQ-031 A shared package SHALL hold the flag encodings (HEAD 01, BODY 11, TAIL 10), the state encodings and the 134-bit word layout constants.
REQ-032 Both error counters SHALL be instances of one sub-module, sat_cnt16: a 16-bit saturating incrementer with asynchronous active-low reset.

Verification
REQ-033 MD_BYTES=8; bytes 0x01 (marker) to 0x08, then 20 payload bytes 0x10..0x23 with 0x23 marked -> word 1: flag 01, invalid 0, data 0x10..0x1F; word 2: flag 10, invalid 12, data 0x20..0x23 then zeros; metadata 0x0102030405060708; pkt_len 20.
REQ-034 MD_BYTES=2; bytes 0xAA (marker), 0xBB, then 16 payload bytes with the 16th marked -> one word, flag 10, invalid 0; metadata 0x000000000000AABB; pkt_len 16.
REQ-035 Marker at the 5th byte with MD_BYTES=8 -> no o_data_wr; ov_short_cnt=1; the next packet is parsed normally.
REQ-036 MAX_PKT_BYTES=32; 40 payload bytes, last marked -> head, then tail invalid 0 with o_pkt_err=1 and pkt_len 32; ov_long_cnt=1; bytes 33..40 produce no output.
REQ-037 Random gaps on i_data_wr during REQ-033, plus reset asserted mid-payload, SHALL show: output identical to the gap-free run; after reset, zero outputs until a new marked start byte.

Source files
------------

// File: rtl/byte_to_word_packer_pkg.sv
// Shared encodings for the byte-to-word packer: FSM states, word flags and the
// 134-bit output word layout.
package byte_to_word_packer_pkg;

  typedef enum logic [1:0] {
    IDLE_S = 2'd0,
    MD_S   = 2'd1,
    DATA_S = 2'd2,
    DROP_S = 2'd3
  } state_e;

  localparam logic [1:0] FLAG_HEAD = 2'b01;
  localparam logic [1:0] FLAG_BODY = 2'b11;
  localparam logic [1:0] FLAG_TAIL = 2'b10;

  localparam int unsigned WORD_W   = 134;
  localparam int unsigned DATA_W   = 128;
  localparam int unsigned FLAG_MSB = 133;
  localparam int unsigned FLAG_LSB = 132;
  localparam int unsigned INV_MSB  = 131;
  localparam int unsigned INV_LSB  = 128;
  localparam int unsigned MD_W     = 64;
  localparam int unsigned LEN_W    = 12;
  localparam int unsigned CNT_W    = 16;

  function automatic logic [WORD_W-1:0] pack_word(input logic [1:0]        flag,
                                                  input logic [3:0]        inv,
                                                  input logic [DATA_W-1:0] data);
    return {flag, inv, data};
  endfunction

endpackage

// File: rtl/byte_to_word_packer_sat_cnt16.sv
// sat_cnt16: 16-bit incrementer that sticks at all-ones instead of wrapping.
module sat_cnt16
  import byte_to_word_packer_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] ov_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign ov_cnt = r_cnt;

endmodule

// File: rtl/byte_to_word_packer.sv
// Packs a marker-delimited byte stream into 128-bit words, peeling off the first
// MD_BYTES bytes of each packet as metadata and truncating over-long payloads.
module byte_to_word_packer
  import byte_to_word_packer_pkg::*;
#(
  parameter int unsigned MD_BYTES      = 8,
  parameter int unsigned MAX_PKT_BYTES = 2048
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [8:0]        iv_data,
  input  logic              i_data_wr,
  output logic [WORD_W-1:0] ov_data,
  output logic              o_data_wr,
  output logic [MD_W-1:0]   ov_metadata,
  output logic              o_metadata_wr,
  output logic [LEN_W-1:0]  ov_pkt_len,
  output logic              o_pkt_err,
  output logic [CNT_W-1:0]  ov_short_cnt,
  output logic [CNT_W-1:0]  ov_long_cnt
);

  localparam logic [3:0]       MD_LAST = 4'(MD_BYTES);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT_BYTES);

  state_e              r_state;
  logic [MD_W-1:0]     r_md;
  logic [3:0]          r_md_cnt;
  logic [3:0]          r_lane;
  logic [LEN_W-1:0]    r_len;
  logic [DATA_W-1:0]   r_word;
  logic                r_first;
  logic [WORD_W-1:0]   r_out_data;
  logic                r_out_wr;
  logic [MD_W-1:0]     r_out_md;
  logic                r_out_md_wr;
  logic [LEN_W-1:0]    r_out_len;
  logic                r_out_err;

  logic                w_marker;
  logic [7:0]          w_byte;
  logic [DATA_W-1:0]   w_word_ins;
  logic [LEN_W-1:0]    w_len_inc;
  logic                w_at_max;
  logic                w_short_inc;
  logic                w_long_inc;

  assign w_marker    = iv_data[8];
  assign w_byte      = iv_data[7:0];
  // Lanes at and beyond r_lane are always zero in r_word, so OR-ing places the byte.
  assign w_word_ins  = r_word | ({w_byte, 120'b0} >> {r_lane, 3'b000});
  assign w_len_inc   = r_len + 1'b1;
  assign w_at_max    = (r_len == MAX_LEN);
  assign w_short_inc = i_data_wr && (r_state == MD_S) && w_marker;
  assign w_long_inc  = i_data_wr && (r_state == DATA_S) && w_at_max;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE_S;
      r_md        <= '0;
      r_md_cnt    <= '0;
      r_lane      <= '0;
      r_len       <= '0;
      r_word      <= '0;
      r_first     <= 1'b0;
      r_out_data  <= '0;
      r_out_wr    <= 1'b0;
      r_out_md    <= '0;
      r_out_md_wr <= 1'b0;
      r_out_len   <= '0;
      r_out_err   <= 1'b0;
    end else begin
      r_out_wr    <= 1'b0;
      r_out_md_wr <= 1'b0;
      r_out_err   <= 1'b0;
      if (i_data_wr) begin
        case (r_state)
          IDLE_S: begin
            if (w_marker) begin
              r_md     <= {56'b0, w_byte};
              r_md_cnt <= 4'd1;
              r_lane   <= '0;
              r_len    <= '0;
              r_word   <= '0;
              r_first  <= 1'b1;
              r_state  <= (MD_LAST == 4'd1) ? DATA_S : MD_S;
            end
          end
          MD_S: begin
            if (w_marker) begin
              r_state <= IDLE_S;
            end else begin
              r_md     <= {r_md[MD_W-9:0], w_byte};
              r_md_cnt <= r_md_cnt + 4'd1;
              if ((r_md_cnt + 4'd1) == MD_LAST) r_state <= DATA_S;
            end
          end
          DATA_S: begin
            if (w_at_max) begin
              // Pending lanes close the packet; a held full word (lane 0) gives 0 invalid.
              r_out_data  <= pack_word(FLAG_TAIL, 4'd0 - r_lane, r_word);
              r_out_wr    <= 1'b1;
              r_out_md    <= r_md;
              r_out_md_wr <= 1'b1;
              r_out_len   <= MAX_LEN;
              r_out_err   <= 1'b1;
              r_state     <= w_marker ? IDLE_S : DROP_S;
            end else if (w_marker) begin
              r_out_data  <= pack_word(FLAG_TAIL, 4'd15 - r_lane, w_word_ins);
              r_out_wr    <= 1'b1;
              r_out_md    <= r_md;
              r_out_md_wr <= 1'b1;
              r_out_len   <= w_len_inc;
              r_state     <= IDLE_S;
            end else begin
              r_len  <= w_len_inc;
              r_lane <= r_lane + 4'd1;
              if (r_lane == 4'd15 && w_len_inc != MAX_LEN) begin
                r_out_data <= pack_word(r_first ? FLAG_HEAD : FLAG_BODY, 4'd0, w_word_ins);
                r_out_wr   <= 1'b1;
                r_first    <= 1'b0;
                r_word     <= '0;
              end else begin
                // A word filled exactly at the limit is held to become the truncated tail.
                r_word <= w_word_ins;
              end
            end
          end
          DROP_S: begin
            if (w_marker) r_state <= IDLE_S;
          end
          default: r_state <= IDLE_S;
        endcase
      end
    end
  end

  sat_cnt16 u_short_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_short_inc),
    .ov_cnt  (ov_short_cnt)
  );

  sat_cnt16 u_long_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_long_inc),
    .ov_cnt  (ov_long_cnt)
  );

  assign ov_data       = r_out_data;
  assign o_data_wr     = r_out_wr;
  assign ov_metadata   = r_out_md;
  assign o_metadata_wr = r_out_md_wr;
  assign ov_pkt_len    = r_out_len;
  assign o_pkt_err     = r_out_err;

endmodule

// File: tb/tb_byte_to_word_packer.sv
// Bench for byte_to_word_packer: three configurations checked every cycle against a
// packet-level model, plus literal expectations for the worked examples.
module tb_byte_to_word_packer;

  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] BODY = 2'b11;
  localparam logic [1:0] TAIL = 2'b10;

  logic         clk;
  logic         rst_n;
  logic [8:0]   din   [3];
  logic         wr    [3];
  logic [133:0] od    [3];
  logic         owr   [3];
  logic [63:0]  omd   [3];
  logic         omdwr [3];
  logic [11:0]  olen  [3];
  logic         oerr  [3];
  logic [15:0]  shc   [3];
  logic [15:0]  lgc   [3];

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: bytes of the packet in flight, drop flag, expected outputs.
  logic [7:0]   pb [3][4200];
  int           pn [3];
  bit           drop [3];
  logic [133:0] e_data [3];
  logic         e_wr [3];
  logic [63:0]  e_md [3];
  logic         e_mdwr [3];
  logic [11:0]  e_len [3];
  logic         e_err [3];
  logic [15:0]  e_sc [3];
  logic [15:0]  e_lc [3];

  // Observed words, for the literal checks.
  logic [133:0] obs_data [3][256];
  logic [63:0]  obs_md   [3][256];
  logic [11:0]  obs_len  [3][256];
  logic         obs_err  [3][256];
  int           obs_n    [3];

  byte_to_word_packer #(.MD_BYTES(8), .MAX_PKT_BYTES(2048)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .iv_data(din[0]), .i_data_wr(wr[0]),
    .ov_data(od[0]), .o_data_wr(owr[0]), .ov_metadata(omd[0]), .o_metadata_wr(omdwr[0]),
    .ov_pkt_len(olen[0]), .o_pkt_err(oerr[0]), .ov_short_cnt(shc[0]), .ov_long_cnt(lgc[0])
  );
  byte_to_word_packer #(.MD_BYTES(2), .MAX_PKT_BYTES(2048)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .iv_data(din[1]), .i_data_wr(wr[1]),
    .ov_data(od[1]), .o_data_wr(owr[1]), .ov_metadata(omd[1]), .o_metadata_wr(omdwr[1]),
    .ov_pkt_len(olen[1]), .o_pkt_err(oerr[1]), .ov_short_cnt(shc[1]), .ov_long_cnt(lgc[1])
  );
  byte_to_word_packer #(.MD_BYTES(8), .MAX_PKT_BYTES(32)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .iv_data(din[2]), .i_data_wr(wr[2]),
    .ov_data(od[2]), .o_data_wr(owr[2]), .ov_metadata(omd[2]), .o_metadata_wr(omdwr[2]),
    .ov_pkt_len(olen[2]), .o_pkt_err(oerr[2]), .ov_short_cnt(shc[2]), .ov_long_cnt(lgc[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int md_of(input int k);
    return (k == 1) ? 2 : 8;
  endfunction

  function automatic int max_of(input int k);
    return (k == 2) ? 32 : 2048;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      pn[k] = 0; drop[k] = 0;
      e_data[k] = '0; e_wr[k] = 0; e_md[k] = '0; e_mdwr[k] = 0;
      e_len[k] = '0; e_err[k] = 0; e_sc[k] = '0; e_lc[k] = '0;
    end
  endtask

  // Emit cnt payload bytes starting at payload offset 'start' as one word.
  task automatic emit(input int k, input logic [1:0] f, input int start, input int cnt,
                      input bit tail, input int len, input bit err);
    logic [127:0] d;
    logic [63:0]  mv;
    int           md;
    md = md_of(k);
    d  = '0;
    mv = '0;
    for (int j = 0; j < cnt; j++) d[127-8*j -: 8] = pb[k][md+start+j];
    for (int j = 0; j < md; j++) mv = {mv[55:0], pb[k][j]};
    e_data[k] = {f, 4'((16 - cnt) % 16), d};
    e_wr[k]   = 1;
    if (tail) begin
      e_mdwr[k] = 1;
      e_md[k]   = mv;
      e_len[k]  = 12'(len);
      e_err[k]  = err;
    end
  endtask

  task automatic step(input int k);
    int md, mx, p, k0;
    bit m;
    logic [7:0] b;
    md = md_of(k); mx = max_of(k);
    m  = din[k][8]; b = din[k][7:0];
    if (!wr[k]) return;
    if (drop[k]) begin
      if (m) drop[k] = 0;
      return;
    end
    if (pn[k] == 0) begin
      if (m) begin pb[k][0] = b; pn[k] = 1; end
      return;
    end
    pb[k][pn[k]] = b;
    pn[k]++;
    if (pn[k] <= md) begin
      if (m) begin
        if (e_sc[k] != 16'hFFFF) e_sc[k]++;
        pn[k] = 0;
      end
      return;
    end
    p = pn[k] - md;
    if (p > mx) begin
      k0 = ((mx - 1) / 16) * 16;
      emit(k, TAIL, k0, mx - k0, 1, mx, 1);
      if (e_lc[k] != 16'hFFFF) e_lc[k]++;
      pn[k] = 0;
      drop[k] = !m;
      return;
    end
    if (m) begin
      k0 = ((p - 1) / 16) * 16;
      emit(k, TAIL, k0, p - k0, 1, p, 0);
      pn[k] = 0;
      return;
    end
    if ((p % 16 == 0) && (p != mx)) emit(k, (p == 16) ? HEAD : BODY, p - 16, 16, 0, 0, 0);
  endtask

  // Compare process: check last cycle's prediction, then advance the model.
  initial begin
    model_reset();
    for (int k = 0; k < 3; k++) obs_n[k] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("out%0d", k),
            {od[k], omd[k], olen[k], owr[k], omdwr[k], oerr[k], shc[k], lgc[k]},
            {e_data[k], e_md[k], e_len[k], e_wr[k], e_mdwr[k], e_err[k], e_sc[k], e_lc[k]});
        if (owr[k] === 1'b1) begin
          obs_data[k][obs_n[k] % 256] = od[k];
          obs_md[k][obs_n[k] % 256]   = omd[k];
          obs_len[k][obs_n[k] % 256]  = olen[k];
          obs_err[k][obs_n[k] % 256]  = oerr[k];
          obs_n[k]++;
        end
        e_wr[k] = 0; e_mdwr[k] = 0; e_err[k] = 0;
      end
      if (rst_n) for (int k = 0; k < 3; k++) step(k);
    end
  end

  task automatic drive(input int k, input bit w, input bit m, input logic [7:0] b);
    @(posedge clk);
    #2;
    for (int j = 0; j < 3; j++) wr[j] = 1'b0;
    din[k] = {m, b};
    wr[k]  = w;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 8'h00);
  endtask

  task automatic send(input int k, input bit m, input logic [7:0] b, input int gmax);
    int g;
    g = (gmax > 0) ? $urandom_range(gmax, 0) : 0;
    repeat (g) drive(k, 0, 0, 8'h00);
    drive(k, 1, m, b);
  endtask

  task automatic send_md8(input int k, input int gmax);
    for (int i = 1; i <= 8; i++) send(k, i == 1, 8'(i), gmax);
  endtask

  task automatic check_033(input string tag, input int n0);
    chk({tag, "_nwords"}, 32'(obs_n[0] - n0), 32'd2);
    chk({tag, "_w1"}, obs_data[0][n0 % 256], {HEAD, 4'd0, 128'h101112131415161718191A1B1C1D1E1F});
    chk({tag, "_w2"}, obs_data[0][(n0 + 1) % 256],
        {TAIL, 4'd12, 128'h20212223000000000000000000000000});
    chk({tag, "_md"}, obs_md[0][(n0 + 1) % 256], 64'h0102030405060708);
    chk({tag, "_len"}, obs_len[0][(n0 + 1) % 256], 12'd20);
  endtask

  task automatic rand_pkt(input int k, input int plmax, input int gmax);
    int md, len;
    bit sh;
    md = md_of(k);
    sh = ($urandom_range(99, 0) < 15);
    if ($urandom_range(9, 0) == 0) send(k, 0, 8'($urandom), gmax);
    len = sh ? $urandom_range(md, 2) : md + $urandom_range(plmax, 1);
    for (int i = 0; i < len; i++) send(k, (i == 0) || (i == len - 1), 8'($urandom), gmax);
  endtask

  initial begin
    int n0;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin wr[k] = 1'b0; din[k] = '0; end
    repeat (3) @(posedge clk);
    #2;
    chk("reset_state", {od[0], omd[0], olen[0], owr[0], omdwr[0], oerr[0], shc[0], lgc[0]}, 0);
    rst_n = 1'b1;

    // Two-word packet, metadata of eight bytes.
    n0 = obs_n[0];
    send_md8(0, 0);
    for (int i = 0; i < 20; i++) send(0, i == 19, 8'(8'h10 + i), 0);
    idle(3);
    check_033("p033", n0);

    // Single-word packet with two metadata bytes.
    n0 = obs_n[1];
    send(1, 1, 8'hAA, 0);
    send(1, 0, 8'hBB, 0);
    for (int i = 0; i < 16; i++) send(1, i == 15, 8'(8'h30 + i), 0);
    idle(3);
    chk("p034_nwords", 32'(obs_n[1] - n0), 32'd1);
    chk("p034_w", obs_data[1][n0 % 256], {TAIL, 4'd0, 128'h303132333435363738393A3B3C3D3E3F});
    chk("p034_md", obs_md[1][n0 % 256], 64'h000000000000AABB);
    chk("p034_len", obs_len[1][n0 % 256], 12'd16);

    // Short packet, then a normal one.
    n0 = obs_n[0];
    for (int i = 1; i <= 5; i++) send(0, (i == 1) || (i == 5), 8'(8'h40 + i), 0);
    idle(3);
    chk("p035_nwords", 32'(obs_n[0] - n0), 32'd0);
    chk("p035_short", shc[0], 16'd1);
    n0 = obs_n[0];
    send_md8(0, 0);
    for (int i = 0; i < 20; i++) send(0, i == 19, 8'(8'h10 + i), 0);
    idle(3);
    check_033("p035_next", n0);

    // Truncation at 32 payload bytes, landing on a word boundary.
    n0 = obs_n[2];
    send_md8(2, 0);
    for (int i = 0; i < 40; i++) send(2, i == 39, 8'(8'h80 + i), 0);
    idle(3);
    chk("p036_nwords", 32'(obs_n[2] - n0), 32'd2);
    chk("p036_head", obs_data[2][n0 % 256], {HEAD, 4'd0, 128'h808182838485868788898A8B8C8D8E8F});
    chk("p036_tail", obs_data[2][(n0 + 1) % 256],
        {TAIL, 4'd0, 128'h909192939495969798999A9B9C9D9E9F});
    chk("p036_err", {obs_err[2][n0 % 256], obs_err[2][(n0 + 1) % 256]}, 2'b01);
    chk("p036_len", obs_len[2][(n0 + 1) % 256], 12'd32);
    chk("p036_long", lgc[2], 16'd1);

    // Same two-word packet with random idle gaps.
    n0 = obs_n[0];
    send_md8(0, 3);
    for (int i = 0; i < 20; i++) send(0, i == 19, 8'(8'h10 + i), 3);
    idle(3);
    check_033("p037_gaps", n0);

    // Reset mid-payload; the remainder of that packet must be ignored.
    send_md8(0, 2);
    for (int i = 0; i < 5; i++) send(0, 0, 8'(8'h10 + i), 2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) wr[k] = 1'b0;
    idle(2);
    chk("p037_rst_cnt", {shc[0], lgc[2], od[0]}, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    n0 = obs_n[0];
    for (int i = 5; i < 19; i++) send(0, 0, 8'(8'h10 + i), 2);
    idle(3);
    chk("p037_rst_quiet", 32'(obs_n[0] - n0), 32'd0);
    n0 = obs_n[0];
    send_md8(0, 2);
    for (int i = 0; i < 20; i++) send(0, i == 19, 8'(8'h10 + i), 2);
    idle(3);
    check_033("p037_after_rst", n0);

    // Randomized traffic on every configuration, plus one default-limit overrun.
    for (int k = 0; k < 3; k++) begin
      repeat (40) rand_pkt(k, (k == 2) ? 50 : 70, 2);
      idle(2);
    end
    send(1, 1, 8'h5A, 0);
    for (int i = 0; i < 2061; i++) send(1, i == 2060, 8'($urandom), 0);
    idle(3);
    chk("long_default", lgc[1], 16'd1);

    idle(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
